inst_encode_loader: RTL and testbench

- Instruction encoder and program loader for the vector core; the encode side of the core's instruction decode stage.
- Accepts field-level instruction descriptors over a valid/ready handshake and packs each into a 32-bit big-endian word (bit 0 = MSB). Encoded words go into a small FIFO.
- Drains the FIFO into instruction memory at consecutive word addresses starting from a loaded base.
- Used by the boot/test path to fill imem before the core is released.

---
 rtl/cpu_isa_pkg.sv | 38 +++
 rtl/inst_fifo.sv | 48 ++++
 rtl/inst_encode_loader.sv | 146 ++++++++++++++
 tb/tb_inst_encode_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the vector core: opcodes, descriptor kinds,
// unary-function list and big-endian field positions.
package cpu_isa_pkg;

    typedef enum logic [2:0] {
        K_RTYPE = 3'd0,
        K_VLD   = 3'd1,
        K_VSD   = 3'd2,
        K_VBEZ  = 3'd3,
        K_VBNEZ = 3'd4,
        K_VNOP  = 3'd5,
        K_RSV6  = 3'd6,
        K_RSV7  = 3'd7
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b101010;
    localparam logic [5:0] OP_VLD   = 6'b100000;
    localparam logic [5:0] OP_VSD   = 6'b100001;
    localparam logic [5:0] OP_VBEZ  = 6'b100010;
    localparam logic [5:0] OP_VBNEZ = 6'b100011;
    localparam logic [5:0] OP_VNOP  = 6'b111100;

    // Big-endian bit k of the ISA maps to word[31-k]; these are the word MSBs.
    localparam int OP_HI  = 31;
    localparam int RD_HI  = 25;
    localparam int RA_HI  = 20;
    localparam int RB_HI  = 15;
    localparam int PPP_HI = 10;
    localparam int WW_HI  = 7;
    localparam int FN_HI  = 5;
    localparam int IMM_HI = 15;

    function automatic logic is_unary(input logic [5:0] f);
        return f inside {6'b000100, 6'b000101, 6'b001101,
                         6'b010000, 6'b010001, 6'b010010};
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO buffering encoded instruction words.
module inst_fifo
    import cpu_isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [31:0]   wdata,
    input  logic          pop,
    output logic [31:0]   head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/inst_encode_loader.sv
// Packs instruction descriptors into 32-bit words and streams them
// into instruction memory from a loaded base address.
module inst_encode_loader
    import cpu_isa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [2:0]        d_kind,
    input  logic [4:0]        d_rd,
    input  logic [4:0]        d_ra,
    input  logic [4:0]        d_rb,
    input  logic [2:0]        d_ppp,
    input  logic [1:0]        d_ww,
    input  logic [5:0]        d_func,
    input  logic [15:0]       d_imm,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE, S_LOAD, S_DRAIN, S_DONE
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       word;
    logic              rsv;
    logic              push;
    logic              pop;
    logic [31:0]       head;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    kind_e             kind;

    assign kind = kind_e'(d_kind);

    always_comb begin
        word = '0;
        rsv  = 1'b0;
        word[RD_HI -: 5] = d_rd;
        case (kind)
            K_RTYPE: begin
                word[OP_HI -: 6]  = OP_RTYPE;
                word[RA_HI -: 5]  = d_ra;
                word[RB_HI -: 5]  = is_unary(d_func) ? 5'd0 : d_rb;
                word[PPP_HI -: 3] = d_ppp;
                word[WW_HI -: 2]  = d_ww;
                word[FN_HI -: 6]  = d_func;
            end
            K_VLD: begin
                word[OP_HI -: 6]   = OP_VLD;
                word[IMM_HI -: 16] = d_imm;
            end
            K_VSD: begin
                word[OP_HI -: 6]   = OP_VSD;
                word[IMM_HI -: 16] = d_imm;
            end
            K_VBEZ: begin
                word[OP_HI -: 6]   = OP_VBEZ;
                word[IMM_HI -: 16] = d_imm;
            end
            K_VBNEZ: begin
                word[OP_HI -: 6]   = OP_VBNEZ;
                word[IMM_HI -: 16] = d_imm;
            end
            K_VNOP: begin
                word[OP_HI -: 6] = OP_VNOP;
            end
            default: begin
                word[OP_HI -: 6] = OP_VNOP;
                rsv = 1'b1;
            end
        endcase
    end

    assign d_ready = (state_q == S_LOAD) && !full;
    assign push    = d_valid && d_ready;
    assign pop     = !empty && (state_q == S_LOAD || state_q == S_DRAIN);
    assign busy    = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);

    inst_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (flush) state_d = S_DRAIN;
            S_DRAIN: if (empty && !im_wr_en) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt      <= '0;
            err      <= 1'b0;
            im_wr_en <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else begin
            state_q  <= state_d;
            im_wr_en <= pop;
            if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
                cnt <= base_addr;
                err <= 1'b0;
            end else begin
                if (pop) cnt <= cnt + 1'b1;
                if (push && rsv) err <= 1'b1;
            end
            if (pop) begin
                im_addr  <= cnt;
                im_wdata <= head;
            end
        end
    end

endmodule

// File: tb/tb_inst_encode_loader.sv
// Directed bench for inst_encode_loader: table of single-word sessions
// plus streaming, address wrap, reserved kind and mid-drain reset.
module tb_inst_encode_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic        flush = 1'b0;
    logic        d_valid = 1'b0;
    logic        d_ready;
    logic [2:0]  d_kind = '0;
    logic [4:0]  d_rd = '0, d_ra = '0, d_rb = '0;
    logic [2:0]  d_ppp = '0;
    logic [1:0]  d_ww = '0;
    logic [5:0]  d_func = '0;
    logic [15:0] d_imm = '0;
    logic        im_wr_en;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wd_q [$];
    logic [9:0]  wa_q [$];

    always #5 clk = ~clk;

    inst_encode_loader #(.FIFO_DEPTH(4), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .flush(flush), .d_valid(d_valid), .d_ready(d_ready),
        .d_kind(d_kind), .d_rd(d_rd), .d_ra(d_ra), .d_rb(d_rb),
        .d_ppp(d_ppp), .d_ww(d_ww), .d_func(d_func), .d_imm(d_imm),
        .im_wr_en(im_wr_en), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always @(negedge clk) begin
        if (im_wr_en) begin
            wd_q.push_back(im_wdata);
            wa_q.push_back(im_addr);
        end
    end

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rd, ra, rb;
        logic [2:0]  ppp;
        logic [1:0]  ww;
        logic [5:0]  func;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_start(input logic [9:0] b);
        base_addr = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic set_desc(input vec_t v);
        d_kind = v.kind; d_rd = v.rd; d_ra = v.ra; d_rb = v.rb;
        d_ppp = v.ppp; d_ww = v.ww; d_func = v.func; d_imm = v.imm;
    endtask

    task automatic send(input vec_t v, input logic fl, output int stalls);
        int k;
        set_desc(v);
        d_valid = 1'b1;
        stalls = 0;
        k = 0;
        @(negedge clk);
        while (!d_ready && k < 100) begin
            stalls++;
            k++;
            @(negedge clk);
        end
        if (!d_ready) check("ready_timeout", d_ready, 1);
        if (fl) flush = 1'b1;
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(nm, done, 1);
    endtask

    function automatic vec_t mk(input logic [2:0] kind, input logic [4:0] rd,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic [2:0] ppp, input logic [1:0] ww,
                                input logic [5:0] func, input logic [15:0] imm,
                                input logic [31:0] exp);
        vec_t v;
        v.kind = kind; v.rd = rd; v.ra = ra; v.rb = rb; v.ppp = ppp;
        v.ww = ww; v.func = func; v.imm = imm; v.exp = exp;
        return v;
    endfunction

    vec_t vecs [8];

    initial begin
        int st;
        int tot;
        int nw;
        vec_t v;

        vecs[0] = mk(3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 2'b10, 6'b000001, 16'h0, 32'hA861_1081);
        vecs[1] = mk(3'd0, 5'd2, 5'd1, 5'd7, 3'b000, 2'b00, 6'b000100, 16'h0, 32'hA841_0004);
        vecs[2] = mk(3'd1, 5'd5, 5'd9, 5'd0, 3'b000, 2'b00, 6'b000000, 16'h1234, 32'h80A0_1234);
        vecs[3] = mk(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 2'b00, 6'b000000, 16'h00FF, 32'h8C20_00FF);
        vecs[4] = mk(3'd5, 5'd31, 5'd5, 5'd9, 3'b111, 2'b11, 6'b111111, 16'hFFFF, 32'hF3E0_0000);
        vecs[5] = mk(3'd2, 5'd0, 5'd31, 5'd31, 3'b000, 2'b00, 6'b000000, 16'hFFFF, 32'h8400_FFFF);
        vecs[6] = mk(3'd3, 5'd31, 5'd31, 5'd0, 3'b000, 2'b00, 6'b000000, 16'h0000, 32'h8BE0_0000);
        vecs[7] = mk(3'd0, 5'd0, 5'd31, 5'd31, 3'b111, 2'b11, 6'b010010, 16'h0, 32'hA81F_07D2);

        // reset state
        #12;
        check("rst_wr_en", im_wr_en, 0);
        check("rst_addr", im_addr, 0);
        check("rst_wdata", im_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", d_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // flush while idle is ignored
        do_flush();
        check("idle_flush_busy", busy, 0);

        foreach (vecs[i]) begin
            wd_q.delete();
            wa_q.delete();
            do_start(10'h010);
            check($sformatf("v%0d_busy", i), busy, 1);
            send(vecs[i], 1'b0, st);
            do_flush();
            wait_done($sformatf("v%0d_done", i));
            check($sformatf("v%0d_nwr", i), wd_q.size(), 1);
            if (wd_q.size() > 0) begin
                check($sformatf("v%0d_addr", i), wa_q[0], 10'h010);
                check($sformatf("v%0d_data", i), wd_q[0], vecs[i].exp);
            end
            check($sformatf("v%0d_err", i), err, 0);
        end

        // six back-to-back descriptors, flush with the last
        wd_q.delete();
        wa_q.delete();
        do_start(10'h100);
        tot = 0;
        for (int i = 0; i < 6; i++) begin
            v = mk(3'd1, 5'(i), 5'd0, 5'd0, 3'd0, 2'd0, 6'd0, 16'(i + 16'hA0), 32'h0);
            send(v, i == 5, st);
            tot += st;
        end
        check("stream_stalls", tot, 0);
        wait_done("stream_done");
        check("stream_nwr", wd_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < wd_q.size()) begin
                check($sformatf("stream_addr%0d", i), wa_q[i], 10'h100 + 10'(i));
                check($sformatf("stream_data%0d", i), wd_q[i],
                      32'h8000_0000 | (32'(i) << 21) | 32'(i + 'hA0));
            end
        end

        // start while busy is ignored; base wraps at top of imem
        wd_q.delete();
        wa_q.delete();
        do_start(10'h3FE);
        do_start(10'h055);
        for (int i = 1; i <= 3; i++) begin
            v = mk(3'd5, 5'(i), 5'd0, 5'd0, 3'd0, 2'd0, 6'd0, 16'h0, 32'h0);
            send(v, 1'b0, st);
        end
        do_flush();
        do_start(10'h077);
        wait_done("wrap_done");
        check("wrap_nwr", wd_q.size(), 3);
        if (wd_q.size() == 3) begin
            check("wrap_a0", wa_q[0], 10'h3FE);
            check("wrap_a1", wa_q[1], 10'h3FF);
            check("wrap_a2", wa_q[2], 10'h000);
            check("wrap_d0", wd_q[0], 32'hF020_0000);
            check("wrap_d2", wd_q[2], 32'hF060_0000);
        end

        // reserved kind encodes as VNOP and sets sticky err
        wd_q.delete();
        wa_q.delete();
        do_start(10'h020);
        v = mk(3'd7, 5'd0, 5'd4, 5'd4, 3'd5, 2'd1, 6'd7, 16'hBEEF, 32'h0);
        send(v, 1'b0, st);
        do_flush();
        wait_done("rsv_done");
        check("rsv_err", err, 1);
        if (wd_q.size() > 0) check("rsv_data", wd_q[0], 32'hF000_0000);
        else check("rsv_nwr", wd_q.size(), 1);
        repeat (3) @(negedge clk);
        check("rsv_err_sticky", err, 1);
        @(posedge clk);
        #1;
        do_start(10'h040);
        check("rsv_err_clr", err, 0);

        // reset asserted mid-drain
        for (int i = 0; i < 3; i++) begin
            v = mk(3'd1, 5'(i), 5'd0, 5'd0, 3'd0, 2'd0, 6'd0, 16'h5, 32'h0);
            send(v, i == 2, st);
        end
        check("mid_drain_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_wr_en", im_wr_en, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        nw = wd_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_wr", wd_q.size(), nw);
        check("arst_idle_done", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
